// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the soft-start/soft-stop duty ramp controller.
// State encodings, duty width and the default duty ceiling.
package pwm_duty_ramp_pkg;

    localparam int unsigned DUTY_W       = 8;
    localparam int unsigned DUTY_MAX_DEF = 100;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRampUp   = 2'd1,
        StRampDown = 2'd2
    } ramp_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                     input logic [DUTY_W-1:0] duty_max);
        return (duty > duty_max) ? duty_max : duty;
    endfunction

endpackage

// File: rtl/pwm_duty_ramp_tick_prescaler.sv
// Modulo-N enabled counter producing a one-cycle tick on each wrap.
// Chained twice in the ramp controller: sclk -> tick, tick -> step.
module pwm_duty_ramp_tick_prescaler #(
    parameter int unsigned N = 10
) (
    input  logic sclk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned    CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start/soft-stop duty controller: walks the duty driven to the pwm block
// toward an accepted target one STEP at a time, one step per CLK_PER_TICK*TICKS_PER_STEP cycles.
module pwm_duty_ramp
    import pwm_duty_ramp_pkg::*;
#(
    parameter int unsigned CLK_PER_TICK   = 10,
    parameter int unsigned TICKS_PER_STEP = 50,
    parameter int unsigned STEP           = 1,
    parameter int unsigned DUTY_MAX       = DUTY_MAX_DEF
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              tgt_valid,
    input  logic [DUTY_W-1:0] tgt_duty,
    output logic              tgt_ready,
    input  logic              soft_stop,
    output logic [31:0]       pwm_par,
    output logic              busy,
    output logic              at_target,
    output logic              clamp_err
);

    localparam logic [DUTY_W-1:0] DMAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEPD = DUTY_W'(STEP);
    localparam logic [DUTY_W:0]   STEP9 = (DUTY_W + 1)'(STEP);

    ramp_state_e       state_q;
    logic [DUTY_W-1:0] cur_q;
    logic [DUTY_W-1:0] target_q;
    logic              clamp_err_q;
    logic              soft_stop_q;

    logic              accept;
    logic              ss_rise;
    logic              ss_fall;
    logic              cnt_clr;
    logic              tick;
    logic              step;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [DUTY_W-1:0] up_next;
    logic [DUTY_W-1:0] dn_next;
    logic [DUTY_W:0]   cur9;
    logic [DUTY_W:0]   tgt9;

    // soft_stop outranks a simultaneous request
    assign accept      = tgt_valid && !soft_stop;
    assign ss_rise     = soft_stop && !soft_stop_q;
    assign ss_fall     = !soft_stop && soft_stop_q;
    assign cnt_clr     = accept || ss_rise || (state_q == StIdle);
    assign tgt_clamped = clamp_duty(tgt_duty, DMAX);

    // Widened compares so cur +/- STEP never wraps past the target
    assign cur9    = {1'b0, cur_q};
    assign tgt9    = {1'b0, target_q};
    assign up_next = (cur9 + STEP9 >= tgt9) ? target_q : cur_q + STEPD;
    assign dn_next = (cur9 <= tgt9 + STEP9) ? target_q : cur_q - STEPD;

    pwm_duty_ramp_tick_prescaler #(
        .N (CLK_PER_TICK)
    ) u_tick (
        .sclk (sclk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (1'b1),
        .tick (tick)
    );

    pwm_duty_ramp_tick_prescaler #(
        .N (TICKS_PER_STEP)
    ) u_step (
        .sclk (sclk),
        .rstn (rstn),
        .clr  (cnt_clr),
        .en   (tick),
        .tick (step)
    );

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            target_q    <= '0;
            clamp_err_q <= 1'b0;
            soft_stop_q <= 1'b0;
        end else begin
            soft_stop_q <= soft_stop;
            clamp_err_q <= accept && (tgt_duty > DMAX);
            if (ss_rise) begin
                target_q <= '0;
                state_q  <= (cur_q != '0) ? StRampDown : StIdle;
            end else if (accept) begin
                target_q <= tgt_clamped;
                if (tgt_clamped > cur_q) begin
                    state_q <= StRampUp;
                end else if (tgt_clamped < cur_q) begin
                    state_q <= StRampDown;
                end else begin
                    state_q <= StIdle;
                end
            end else if (ss_fall && state_q != StIdle) begin
                // Releasing soft_stop freezes the duty where it is
                target_q <= cur_q;
                state_q  <= StIdle;
            end else if (step) begin
                unique case (state_q)
                    StRampUp: begin
                        cur_q <= up_next;
                        if (up_next == target_q) state_q <= StIdle;
                    end
                    StRampDown: begin
                        cur_q <= dn_next;
                        if (dn_next == target_q) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign pwm_par   = {{(32 - DUTY_W){1'b0}}, cur_q};
    assign busy      = (state_q != StIdle);
    assign at_target = (state_q == StIdle);
    assign tgt_ready = !soft_stop;
    assign clamp_err = clamp_err_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: stimulus predicts each duty step (value and cycle),
// a negedge monitor pops predictions whenever pwm_par changes.
module tb_pwm_duty_ramp;

    localparam int STEP_CYC = 50;
    localparam int STEPV    = 10;
    localparam int DMAX     = 100;

    logic        sclk = 1'b0;
    logic        rstn = 1'b0;
    logic        tgt_valid = 1'b0;
    logic [7:0]  tgt_duty = 8'd0;
    logic        soft_stop = 1'b0;
    logic        tgt_ready;
    logic [31:0] pwm_par;
    logic        busy;
    logic        at_target;
    logic        clamp_err;

    pwm_duty_ramp #(
        .CLK_PER_TICK   (10),
        .TICKS_PER_STEP (5),
        .STEP           (10),
        .DUTY_MAX       (100)
    ) dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .tgt_valid (tgt_valid),
        .tgt_duty  (tgt_duty),
        .tgt_ready (tgt_ready),
        .soft_stop (soft_stop),
        .pwm_par   (pwm_par),
        .busy      (busy),
        .at_target (at_target),
        .clamp_err (clamp_err)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        int cyc;
        int val;
        bit fin;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   m_base    = 0;
    int   last_pwm  = 0;
    int   clamp_cyc = -1;
    int   n_chk     = 0;
    int   n_pass    = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference ramp: plain arithmetic walk from c toward t, one value per step period
    task automatic push_ramp(input int a, input int c, input int t);
        int v = c;
        int k = 1;
        while (v != t) begin
            if (t > v) v = (v + STEPV >= t) ? t : v + STEPV;
            else       v = (v <= t + STEPV) ? t : v - STEPV;
            exp_q.push_back('{a + STEP_CYC * k, v, v == t});
            k++;
        end
    endtask

    // Drop predictions superseded at edge a; return duty held just before a
    task automatic cut_at(input int a, output int c);
        while (exp_q.size() > 0 && exp_q[$].cyc >= a) void'(exp_q.pop_back());
        c = (exp_q.size() > 0) ? exp_q[$].val : m_base;
    endtask

    // Call right after a negedge; returns at the negedge following the accept edge
    task automatic issue_target(input int d);
        int a = cyc + 1;
        int t = (d > DMAX) ? DMAX : d;
        int c;
        cut_at(a, c);
        check("tgt_ready_idle", int'(tgt_ready), 1);
        tgt_valid = 1'b1;
        tgt_duty  = 8'(d);
        if (d > DMAX) clamp_cyc = a;
        push_ramp(a, c, t);
        @(negedge sclk);
        tgt_valid = 1'b0;
        check("busy_on_accept", int'(busy), int'(t != c));
        check("at_target_on_accept", int'(at_target), int'(t == c));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            @(negedge sclk);
            n++;
        end
        check("ramp_done_in_time", exp_q.size(), 0);
        exp_q.delete();
        @(negedge sclk);
        check("idle_at_target", int'(at_target), 1);
    endtask

    always @(negedge sclk) begin
        exp_t e;
        if (rstn) begin
            if (int'(pwm_par) != last_pwm) begin
                last_pwm = int'(pwm_par);
                if (exp_q.size() == 0) begin
                    check("unexpected_pwm_change", last_pwm, m_base);
                    m_base = last_pwm;
                end else begin
                    e = exp_q.pop_front();
                    m_base = e.val;
                    check("pwm_value", last_pwm, e.val);
                    check("pwm_step_cycle", cyc, e.cyc);
                    check("at_target_on_step", int'(at_target), int'(e.fin));
                    check("busy_on_step", int'(busy), int'(!e.fin));
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("missed_step", last_pwm, exp_q[0].val);
                m_base = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            check("clamp_err", int'(clamp_err), int'(cyc == clamp_cyc));
            check("pwm_par_upper", int'(pwm_par[31:8]), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int a;
        repeat (3) @(negedge sclk);
        check("reset_pwm_par", int'(pwm_par), 0);
        check("reset_tgt_ready", int'(tgt_ready), 1);
        check("reset_at_target", int'(at_target), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_clamp_err", int'(clamp_err), 0);
        rstn = 1'b1;
        @(negedge sclk);

        issue_target(40);  wait_idle(400);
        issue_target(0);   wait_idle(400);
        issue_target(35);  wait_idle(400);
        check("overshoot_final", int'(pwm_par), 35);
        issue_target(0);   wait_idle(400);
        issue_target(150); wait_idle(800);
        check("clamped_final", int'(pwm_par), 100);
        issue_target(0);   wait_idle(800);

        // Reverse mid-ramp
        issue_target(80);
        repeat (150) @(negedge sclk);
        check("retarget_start", int'(pwm_par), 30);
        issue_target(10);
        check("retarget_busy", int'(busy), 1);
        wait_idle(400);

        // soft_stop racing a request
        issue_target(80);
        repeat (250) @(negedge sclk);
        check("soft_stop_start", int'(pwm_par), 60);
        a = cyc + 1;
        cut_at(a, c);
        soft_stop = 1'b1;
        tgt_valid = 1'b1;
        tgt_duty  = 8'd90;
        push_ramp(a, c, 0);
        #1;
        check("soft_stop_ready", int'(tgt_ready), 0);
        repeat (20) @(negedge sclk);
        tgt_valid = 1'b0;
        wait_idle(600);
        check("soft_stop_final", int'(pwm_par), 0);
        soft_stop = 1'b0;
        #1;
        check("release_ready", int'(tgt_ready), 1);
        repeat (100) @(negedge sclk);

        for (int i = 0; i < 15; i++) begin
            issue_target(int'($urandom_range(0, 140)));
            repeat ($urandom_range(1, 400)) @(negedge sclk);
        end
        wait_idle(1500);

        // Asynchronous reset mid-ramp
        issue_target((m_base > 50) ? 0 : 100);
        repeat (120) @(negedge sclk);
        #2;
        exp_q.delete();
        m_base    = 0;
        last_pwm  = 0;
        clamp_cyc = -1;
        rstn      = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_par), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_at_target", int'(at_target), 1);
        @(negedge sclk);
        rstn = 1'b1;
        @(negedge sclk);
        issue_target(20);
        wait_idle(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
